mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between instruction fetch (IF) and load/store (MEM).
//  - Sits between PC_reg/IF, the MEM stage and the RAM interface.
//  - Grants one multi-cycle transaction at a time; MEM has priority, with a starvation guard for IF.
//  - Drops in-flight fetches on branch flush.
//  - Raises per-requester stall requests to the pipeline stall controller.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch (IF) and the
//   load/store stage (MEM). One RAM transaction is in flight at a time.
//   MEM wins ties. A streak counter makes sure a waiting fetch gets the port
//   after at most MEM_STREAK_MAX consecutive MEM grants. A branch flush
//   cancels a pending fetch. It also silently drops a fetch that is already
//   in flight: the RAM handshake still completes, but its data is discarded.
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   if_req_i / if_addr_i        fetch request (level) and pc
//   if_flush_i                  branch taken; cancels pending or in-flight fetch
//   if_ack_o / if_inst_o        one-cycle fetch completion pulse and instruction
//   if_stall_o                  fetch is waiting (combinational)
//   mem_req_i / mem_we_i        load/store request (level), 1 = store
//   mem_be_i / mem_addr_i       byte enables and data address
//   mem_wdata_i                 store data
//   mem_ack_o / mem_rdata_o     one-cycle load/store completion pulse and load data
//   mem_stall_o                 load/store is waiting (combinational)
//   ram_req_o .. ram_wdata_o    RAM request; fields held stable until ram_ack_i
//   ram_ack_i / ram_rdata_i     RAM completion pulse and read data
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    input  logic                  if_flush_i,
    output logic                  if_ack_o,
    output logic [DATA_W-1:0]     if_inst_o,
    output logic                  if_stall_o,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [DATA_W/8-1:0]   mem_be_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    output logic                  mem_ack_o,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic                  mem_stall_o,
    output logic                  ram_req_o,
    output logic                  ram_we_o,
    output logic [DATA_W/8-1:0]   ram_be_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [DATA_W-1:0]     ram_wdata_o,
    input  logic                  ram_ack_i,
    input  logic [DATA_W-1:0]     ram_rdata_i
);

    localparam logic [3:0] STREAK_MAX = 4'(MEM_STREAK_MAX);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, IF_DROP} state_t;

    state_t                state_reg;
    logic [3:0]            streak_reg;
    logic                  ram_req_reg;
    logic                  ram_we_reg;
    logic [DATA_W/8-1:0]   ram_be_reg;
    logic [ADDR_W-1:0]     ram_addr_reg;
    logic [DATA_W-1:0]     ram_wdata_reg;
    logic                  if_ack_reg;
    logic [DATA_W-1:0]     if_inst_reg;
    logic                  mem_ack_reg;
    logic [DATA_W-1:0]     mem_rdata_reg;

    // A requester whose ack is pulsing this cycle is still holding req high
    // for the transaction that just finished, so it is not eligible again yet.
    logic       if_elig;
    logic       mem_elig;
    logic       grant_mem;
    logic       grant_if;
    logic [3:0] streak_sat_inc;

    assign if_elig   = if_req_i & ~if_ack_reg & ~if_flush_i;
    assign mem_elig  = mem_req_i & ~mem_ack_reg;
    // MEM wins unless IF has already waited through a full streak.
    assign grant_mem = mem_elig & ~(if_elig & (streak_reg >= STREAK_MAX));
    assign grant_if  = if_elig & ~grant_mem;
    // The streak saturates at the limit. Once IF becomes eligible, the
    // "streak reached" condition is already true and IF wins immediately.
    assign streak_sat_inc = (streak_reg >= STREAK_MAX) ? STREAK_MAX : streak_reg + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            streak_reg    <= '0;
            ram_req_reg   <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_be_reg    <= '0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            if_ack_reg    <= 1'b0;
            if_inst_reg   <= '0;
            mem_ack_reg   <= 1'b0;
            mem_rdata_reg <= '0;
        end else begin
            // Ack outputs are single-cycle pulses.
            if_ack_reg  <= 1'b0;
            mem_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_mem) begin
                        ram_req_reg   <= 1'b1;
                        ram_we_reg    <= mem_we_i;
                        ram_be_reg    <= mem_be_i;
                        ram_addr_reg  <= mem_addr_i;
                        ram_wdata_reg <= mem_wdata_i;
                        // Only count the streak while a fetch is actually waiting.
                        streak_reg    <= if_req_i ? streak_sat_inc : 4'd0;
                        state_reg     <= MEM_BUSY;
                    end else if (grant_if) begin
                        ram_req_reg   <= 1'b1;
                        ram_we_reg    <= 1'b0;
                        ram_be_reg    <= '1;
                        ram_addr_reg  <= if_addr_i;
                        ram_wdata_reg <= '0;
                        streak_reg    <= 4'd0;
                        state_reg     <= IF_BUSY;
                    end
                end
                IF_BUSY: begin
                    if (ram_ack_i) begin
                        ram_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                        if (!if_flush_i) begin
                            if_inst_reg <= ram_rdata_i;
                            if_ack_reg  <= 1'b1;
                        end
                    end else if (if_flush_i) begin
                        // The RAM handshake cannot be aborted; finish it and discard.
                        state_reg <= IF_DROP;
                    end
                end
                IF_DROP: begin
                    if (ram_ack_i) begin
                        ram_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                MEM_BUSY: begin
                    if (ram_ack_i) begin
                        ram_req_reg   <= 1'b0;
                        mem_rdata_reg <= ram_rdata_i;
                        mem_ack_reg   <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ram_req_o   = ram_req_reg;
    assign ram_we_o    = ram_we_reg;
    assign ram_be_o    = ram_be_reg;
    assign ram_addr_o  = ram_addr_reg;
    assign ram_wdata_o = ram_wdata_reg;
    assign if_ack_o    = if_ack_reg;
    assign if_inst_o   = if_inst_reg;
    assign mem_ack_o   = mem_ack_reg;
    assign mem_rdata_o = mem_rdata_reg;

    assign if_stall_o  = if_elig;
    assign mem_stall_o = mem_elig;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A transaction-level model tracks
//   port ownership, pending acks and the MEM streak. It is compared against
//   every DUT output once per cycle. Directed sequences pin the model with
//   hand-computed latencies, grant order and data values.
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_ack_o;
    logic [31:0] if_inst_o;
    logic        if_stall_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_ack_o;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_ack_i;
    logic [31:0] ram_rdata_i;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MEM_STREAK_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_flush_i(if_flush_i),
        .if_ack_o(if_ack_o),
        .if_inst_o(if_inst_o),
        .if_stall_o(if_stall_o),
        .mem_req_i(mem_req_i),
        .mem_we_i(mem_we_i),
        .mem_be_i(mem_be_i),
        .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_ack_o(mem_ack_o),
        .mem_rdata_o(mem_rdata_o),
        .mem_stall_o(mem_stall_o),
        .ram_req_o(ram_req_o),
        .ram_we_o(ram_we_o),
        .ram_be_o(ram_be_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_ack_i(ram_ack_i),
        .ram_rdata_i(ram_rdata_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM responder: ack arrives in the ram_lat-th cycle of a request.
    int          ram_lat  = 1;
    logic [31:0] ram_data = 32'h0;
    int          ram_cnt  = 0;
    initial begin
        ram_ack_i   = 1'b0;
        ram_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (ram_req_o && !ram_ack_i) ram_cnt++;
            else ram_cnt = 0;
            ram_ack_i   = (ram_cnt == ram_lat);
            ram_rdata_i = ram_ack_i ? ram_data : $urandom();
        end
    end

    // Transaction-level model: who owns the port, is the fetch cancelled,
    // which ack is due, and how long IF has been passed over.
    bit          m_busy = 0;
    bit          m_is_if = 0;
    bit          m_drop = 0;
    int          m_streak = 0;
    bit          pa_if, pa_mem, w_if, w_mem;
    logic        e_req = 0, e_we = 0, e_if_ack = 0, e_mem_ack = 0;
    logic [3:0]  e_be = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_if_inst = 0, e_mem_rdata = 0;
    byte         mlog[$];
    logic [31:0] dlog[$];
    logic        dut_req_prev = 0;

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 0; m_is_if = 0; m_drop = 0; m_streak = 0;
                e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
                e_if_ack = 0; e_mem_ack = 0; e_if_inst = 0; e_mem_rdata = 0;
            end else begin
                pa_if = e_if_ack;
                pa_mem = e_mem_ack;
                e_if_ack = 0;
                e_mem_ack = 0;
                if (!m_busy) begin
                    w_if  = if_req_i && !pa_if && !if_flush_i;
                    w_mem = mem_req_i && !pa_mem;
                    if (w_mem && !(w_if && m_streak >= SMAX)) begin
                        m_busy = 1; m_is_if = 0;
                        e_req = 1; e_we = mem_we_i; e_be = mem_be_i;
                        e_addr = mem_addr_i; e_wdata = mem_wdata_i;
                        m_streak = if_req_i ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
                        mlog.push_back("M");
                    end else if (w_if) begin
                        m_busy = 1; m_is_if = 1; m_drop = 0;
                        e_req = 1; e_we = 0; e_be = 4'hF;
                        e_addr = if_addr_i; e_wdata = 0;
                        m_streak = 0;
                        mlog.push_back("I");
                    end
                end else if (ram_ack_i) begin
                    m_busy = 0;
                    e_req = 0;
                    if (!m_is_if) begin
                        e_mem_rdata = ram_rdata_i;
                        e_mem_ack = 1;
                    end else if (!m_drop && !if_flush_i) begin
                        e_if_inst = ram_rdata_i;
                        e_if_ack = 1;
                    end
                    m_drop = 0;
                end else if (m_is_if && if_flush_i) begin
                    m_drop = 1;
                end
            end
            #2;
            chk("ram_req", ram_req_o, e_req);
            if (e_req || !rst_n) begin
                chk("ram_we", ram_we_o, e_we);
                chk("ram_be", ram_be_o, e_be);
                chk("ram_addr", ram_addr_o, e_addr);
                chk("ram_wdata", ram_wdata_o, e_wdata);
            end
            chk("if_ack", if_ack_o, e_if_ack);
            chk("mem_ack", mem_ack_o, e_mem_ack);
            chk("if_inst", if_inst_o, e_if_inst);
            chk("mem_rdata", mem_rdata_o, e_mem_rdata);
            chk("if_stall", if_stall_o, if_req_i & ~e_if_ack & ~if_flush_i);
            chk("mem_stall", mem_stall_o, mem_req_i & ~e_mem_ack);
            if (ram_req_o && !dut_req_prev) dlog.push_back(ram_addr_o);
            dut_req_prev = ram_req_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    string exp_order;
    int    n;
    int    req_cyc;

    initial begin : stimulus
        rst_n = 1'b0;
        if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
        mem_req_i = 0; mem_we_i = 0; mem_be_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        exp_order = "MMMMIMMMMI";

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_req", ram_req_o, 0);
        chk("rst_if_ack", if_ack_o, 0);
        chk("rst_ram_addr", ram_addr_o, 0);
        chk("rst_mem_rdata", mem_rdata_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch 0x100, RAM acks in its first request cycle: ack at cycle 3
        ram_lat = 1; ram_data = 32'h0000_0013;
        if_req_i = 1; if_addr_i = 32'h100;
        n = 1;
        while (!if_ack_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_latency", n, 3);
        chk("fetch_inst", if_inst_o, 32'h13);
        if_req_i = 0;
        @(negedge clk);
        chk("fetch_ack_single", if_ack_o, 0);
        chk("fetch_no_regrant", ram_req_o, 0);
        chk("fetch_inst_hold", if_inst_o, 32'h13);

        // Both requesting continuously. IF is flushed during MEM ack cycles,
        // so every arbitration sees both requesters together.
        ram_lat = 2;
        mlog.delete(); dlog.delete();
        if_addr_i = 32'h1000; mem_addr_i = 32'h2000; mem_we_i = 0; mem_be_i = 4'hF;
        if_req_i = 1; mem_req_i = 1;
        n = 0;
        while (mlog.size() < 10 && n < 300) begin
            @(negedge clk);
            n++;
            if_flush_i = mem_ack_o;
        end
        while (!if_ack_o && n < 300) begin
            @(negedge clk);
            n++;
            if_flush_i = mem_ack_o;
        end
        if_req_i = 0; mem_req_i = 0; if_flush_i = 0;
        chk("order_count_model", mlog.size(), 10);
        chk("order_count_dut", dlog.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < mlog.size()) chk("order_model", mlog[i], exp_order[i]);
            if (i < dlog.size()) chk("order_dut", dlog[i], (exp_order[i] == "I") ? 32'h1000 : 32'h2000);
        end
        @(negedge clk);

        // Store: fields stable for all request cycles, then one mem_ack pulse
        ram_lat = 3;
        mem_we_i = 1; mem_be_i = 4'b0011; mem_addr_i = 32'h2000; mem_wdata_i = 32'hDEAD_BEEF;
        mem_req_i = 1;
        n = 0; req_cyc = 0;
        while (!mem_ack_o && n < 20) begin
            @(negedge clk);
            n++;
            if (ram_req_o) begin
                req_cyc++;
                chk("store_we", ram_we_o, 1);
                chk("store_be", ram_be_o, 4'b0011);
                chk("store_addr", ram_addr_o, 32'h2000);
                chk("store_wdata", ram_wdata_o, 32'hDEAD_BEEF);
            end
        end
        chk("store_ack", mem_ack_o, 1);
        chk("store_req_cycles", req_cyc, 3);
        mem_req_i = 0; mem_we_i = 0;
        @(negedge clk);
        chk("store_ack_single", mem_ack_o, 0);

        // Flush during IF_BUSY: the dropped fetch completes silently, then the new pc is fetched
        ram_lat = 4; ram_data = 32'hAAAA_0001;
        if_req_i = 1; if_addr_i = 32'h300;
        n = 0;
        while (!ram_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drop_fetch_issued", ram_req_o, 1);
        if_flush_i = 1; if_addr_i = 32'h400;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if_flush_i = 0;
            chk("drop_no_ack", if_ack_o, 0);
        end while (ram_req_o && n < 20);
        chk("drop_hold_cycles", n, 4);
        ram_data = 32'h0000_0093;
        n = 0;
        while (!ram_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("refetch_gap", n, 1);
        chk("refetch_addr", ram_addr_o, 32'h400);
        n = 0;
        while (!if_ack_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("refetch_ack", if_ack_o, 1);
        chk("refetch_inst", if_inst_o, 32'h93);
        if_req_i = 0;
        @(negedge clk);

        // Flush in the same cycle as ram_ack_i: no ack, port released
        ram_lat = 2; ram_data = 32'h0000_0055;
        if_req_i = 1; if_addr_i = 32'h500;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!ram_ack_i && n < 20);
        chk("flush_ack_seen", ram_ack_i, 1);
        if_flush_i = 1; if_req_i = 0;
        @(negedge clk);
        if_flush_i = 0;
        chk("flush_ack_released", ram_req_o, 0);
        repeat (3) begin
            chk("flush_ack_no_ack", if_ack_o, 0);
            @(negedge clk);
        end
        chk("flush_ack_inst_hold", if_inst_o, 32'h93);

        // MEM transaction ignores flush
        ram_lat = 2; ram_data = 32'hCAFE_F00D;
        mem_we_i = 0; mem_be_i = 4'hF; mem_addr_i = 32'h2400; mem_wdata_i = 0;
        mem_req_i = 1; if_flush_i = 1;
        n = 0;
        while (!mem_ack_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_flush_ack", mem_ack_o, 1);
        chk("mem_flush_rdata", mem_rdata_o, 32'hCAFE_F00D);
        chk("mem_flush_no_if_ack", if_ack_o, 0);
        mem_req_i = 0; if_flush_i = 0;
        @(negedge clk);

        // Reset in the middle of IF_BUSY
        ram_lat = 5; ram_data = 32'h0000_0777;
        if_req_i = 1; if_addr_i = 32'h600;
        n = 0;
        while (!ram_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_issued", ram_req_o, 1);
        @(negedge clk);
        rst_n = 1'b0; if_req_i = 0;
        #1;
        chk("rst_mid_req_async", ram_req_o, 0);
        chk("rst_mid_inst", if_inst_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("rst_mid_no_ack", if_ack_o, 0);
            chk("rst_mid_idle", ram_req_o, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
